fib_bcd: RTL and testbench

FIB_BCD -- requirements
Module: fib_bcd

---
 rtl/fib_bcd.sv | 116 +++++++++++
 tb/tb_fib_bcd.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fib_bcd.sv
// Sequential double-dabble binary-to-BCD converter fed by the Fibonacci generator stage.
// Define FIB_BCD_CHANGE_DETECT_EN to also start a conversion whenever `in` differs from the last captured value.
module fib_bcd #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      in,
    input  logic                  in_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  drop
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Add 3 to each digit >= 5 so the following left shift carries correctly into the next digit.
    function automatic logic [4*DIGITS-1:0] add3_digits(input logic [4*DIGITS-1:0] s);
        logic [4*DIGITS-1:0] r;
        r = s;
        for (int k = 0; k < DIGITS; k++) begin
            if (s[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = s[4*k +: 4] + 4'd3;
            end else begin
                r[4*k +: 4] = s[4*k +: 4];
            end
        end
        return r;
    endfunction

    state_t                r_state;
    logic [WIDTH-1:0]      r_shreg;
    logic [4*DIGITS-1:0]   r_scratch;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [CW-1:0]         r_cnt;
    logic                  r_done;
    logic                  r_drop;
    logic                  w_start;
    logic [4*DIGITS-1:0]   w_adj;
    logic [4*DIGITS-1:0]   w_next_scratch;

`ifdef FIB_BCD_CHANGE_DETECT_EN
    logic [WIDTH-1:0]      r_last;
    assign w_start = in_valid | (in != r_last);
`else
    assign w_start = in_valid;
`endif

    // The digit shifted out of the top of the scratch register is discarded, keeping the lower digits exact.
    assign w_adj          = add3_digits(r_scratch);
    assign w_next_scratch = (4*DIGITS)'({w_adj, r_shreg[WIDTH-1]});

    // Conversion sequencer: capture, WIDTH shift steps, then a single load of the finished result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_scratch <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_drop    <= 1'b0;
`ifdef FIB_BCD_CHANGE_DETECT_EN
            r_last    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_drop <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_shreg   <= in;
                        r_scratch <= '0;
                        r_cnt     <= CW'(WIDTH);
                        r_state   <= SHIFT;
`ifdef FIB_BCD_CHANGE_DETECT_EN
                        r_last    <= in;
`endif
                    end else begin
                        r_state   <= IDLE;
                    end
                end
                SHIFT: begin
                    r_drop    <= w_start;
                    r_scratch <= w_next_scratch;
                    r_shreg   <= r_shreg << 1;
                    r_cnt     <= r_cnt - CW'(1);
                    r_state   <= (r_cnt == CW'(1)) ? LOAD : SHIFT;
                end
                LOAD: begin
                    r_drop  <= w_start;
                    r_bcd   <= r_scratch;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bcd  = r_bcd;
    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign drop = r_drop;

endmodule

// File: tb/tb_fib_bcd.sv
// Scoreboard bench for fib_bcd: a 4-bit and an 8-bit instance, expected BCD queued at request time.
module tb_fib_bcd;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in4;
    logic       v4;
    logic [7:0] bcd4;
    logic       busy4, done4, drop4;
    logic [7:0] in8;
    logic       v8;
    logic [7:0] bcd8;
    logic       busy8, done8, drop8;

    int n_checks = 0;
    int n_errors = 0;
    int ndone4   = 0;
    int ndone8   = 0;
    int ndrop4   = 0;
    int cyc      = 0;
    logic [7:0] q4[$];
    logic [7:0] q8[$];

    always #5 clk = ~clk;

    fib_bcd #(.WIDTH(4), .DIGITS(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in(in4), .in_valid(v4),
        .bcd(bcd4), .busy(busy4), .done(done4), .drop(drop4)
    );

    fib_bcd #(.WIDTH(8), .DIGITS(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in(in8), .in_valid(v8),
        .bcd(bcd8), .busy(busy8), .done(done8), .drop(drop8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((((v / 10) % 10) * 16) + (v % 10));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: every done pulse pops one expected value.
    always @(negedge clk) begin
        if (rst_n) begin
            if (drop4) ndrop4++;
            if (done4) begin
                ndone4++;
                if (q4.size() == 0) check("spurious_done4", 32'd1, 32'd0);
                else check("bcd4", {24'd0, bcd4}, {24'd0, q4.pop_front()});
            end
            if (done8) begin
                ndone8++;
                if (q8.size() == 0) check("spurious_done8", 32'd1, 32'd0);
                else check("bcd8", {24'd0, bcd8}, {24'd0, q8.pop_front()});
            end
        end
    end

    task automatic run_conv(input bit wide, input int val, output int done_cyc);
        int         busy_cnt;
        int         n;
        int         holds;
        int         lat;
        logic [7:0] prev;
        lat  = wide ? 9 : 5;
        prev = wide ? bcd8 : bcd4;
        if (wide) begin
            in8 = 8'(val); v8 = 1'b1; q8.push_back(to_bcd(val));
        end else begin
            in4 = 4'(val); v4 = 1'b1; q4.push_back(to_bcd(val));
        end
        tick();
        v4 = 1'b0;
        v8 = 1'b0;
        busy_cnt = (wide ? busy8 : busy4) ? 1 : 0;
        n = 0;
        holds = 0;
        while (!(wide ? done8 : done4) && n < 60) begin
            if ((wide ? bcd8 : bcd4) !== prev) holds++;
            tick();
            n++;
            if (wide ? busy8 : busy4) busy_cnt++;
        end
        check("latency", n, lat);
        check("busy_cycles", busy_cnt, lat);
        check("bcd_hold", holds, 0);
        done_cyc = cyc;
    endtask

    initial begin
        int d1, d2, base, n;
        rst_n = 1'b0;
        in4 = 4'd0; v4 = 1'b0; in8 = 8'd0; v8 = 1'b0;
        #12;
        check("rst_bcd", {24'd0, bcd4}, 32'd0);
        check("rst_busy", {31'd0, busy4}, 32'd0);
        check("rst_done", {31'd0, done4}, 32'd0);
        check("rst_drop", {31'd0, drop4}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
`ifdef FIB_BCD_CHANGE_DETECT_EN
        begin
            int seq[7] = '{1, 1, 2, 3, 5, 8, 13};
            int last = 0;
            for (int i = 0; i < 7; i++) begin
                in4 = 4'(seq[i]);
                if (seq[i] != last) q4.push_back(to_bcd(seq[i]));
                last = seq[i];
                repeat (6) tick();
            end
            repeat (10) tick();
            check("cd_conversions", ndone4, 6);
            check("cd_drops", ndrop4, 0);
        end
`else
        run_conv(1'b0, 13, d1);
        run_conv(1'b0, 15, d1);
        run_conv(1'b0, 0, d2);
        check("b2b_gap", d2 - d1, 6);
        for (int v = 0; v < 16; v++) run_conv(1'b0, v, d1);

        // Request arriving mid-conversion must be dropped and leave the 9 intact.
        repeat (3) tick();
        base = ndone4;
        in4 = 4'd9; v4 = 1'b1; q4.push_back(to_bcd(9));
        tick();
        v4 = 1'b0;
        tick();
        in4 = 4'd6; v4 = 1'b1;
        tick();
        v4 = 1'b0;
        check("drop_pulse", {31'd0, drop4}, 32'd1);
        tick();
        check("drop_clear", {31'd0, drop4}, 32'd0);
        n = 0;
        while (!done4 && n < 20) begin tick(); n++; end
        repeat (8) tick();
        check("single_done", ndone4 - base, 1);
        check("drop_count", ndrop4, 1);

        // Reset on the second shift edge aborts the conversion of 12.
        in4 = 4'd12; v4 = 1'b1; q4.push_back(to_bcd(12));
        tick();
        v4 = 1'b0;
        tick();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q4.delete();
        base = ndone4;
        #1;
        check("abort_bcd", {24'd0, bcd4}, 32'd0);
        check("abort_busy", {31'd0, busy4}, 32'd0);
        check("abort_done", {31'd0, done4}, 32'd0);
        repeat (3) tick();
        check("abort_bcd_held", {24'd0, bcd4}, 32'd0);
        rst_n = 1'b1;
        repeat (8) tick();
        check("no_done_abort", ndone4 - base, 0);
        run_conv(1'b0, 7, d1);

        run_conv(1'b1, 255, d1);
        run_conv(1'b1, 0, d1);
        run_conv(1'b1, 99, d1);
        run_conv(1'b1, 100, d1);
        run_conv(1'b1, 173, d1);
        repeat (4) tick();
`endif
        check("q4_empty", q4.size(), 0);
        check("q8_empty", q8.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
